spio_hss_multiplexer_pkt_scheduler: RTL and testbench



---
 rtl/spio_hss_multiplexer_pkt_scheduler_pkg.sv | 28 ++
 rtl/spio_hss_multiplexer_rr_pick.sv | 27 ++
 rtl/spio_hss_multiplexer_pkt_scheduler.sv | 178 +++++++++++++++++
 tb/tb_spio_hss_multiplexer_pkt_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spio_hss_multiplexer_pkt_scheduler_pkg.sv
// Shared constants and types for the HSS multiplexer packet scheduler.
// Holds the channel count, scheduler state encoding and default frame/credit sizing.
package spio_hss_multiplexer_pkt_scheduler_pkg;

  // Link-level constants
  localparam int NUM_CHANS = 8;   // outbound packet channels on this link
  localparam int CHAN_BITS = 3;   // width of a channel index

  // Scheduler defaults
  localparam int MAX_PKTS_DFLT  = 8;   // packets per frame before forced close
  localparam int FILL_TO_DFLT   = 16;  // idle cycles tolerated in an open frame
  localparam int CRDT_BITS_DFLT = 4;   // frame-credit counter width
  localparam int INIT_CRDT_DFLT = 8;   // credits available after reset

  // Scheduler FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FILL  = 2'd2,
    ST_CLOSE = 2'd3
  } sched_state_e;

  // Next channel index, wrapping 7 -> 0
  function automatic logic [CHAN_BITS-1:0] chan_inc(input logic [CHAN_BITS-1:0] ch);
    return ch + 1'b1;
  endfunction

endpackage

// File: rtl/spio_hss_multiplexer_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or after rr_ptr, wrapping.
// Also used by the packet dispatcher's output arbitration.
module spio_hss_multiplexer_rr_pick
  import spio_hss_multiplexer_pkt_scheduler_pkg::*;
(
  input  logic [NUM_CHANS-1:0] elig,
  input  logic [CHAN_BITS-1:0] rr_ptr,
  output logic [CHAN_BITS-1:0] pick,
  output logic                 any
);

  logic [CHAN_BITS-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest eligible channel wins
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = |elig;
    for (int k = NUM_CHANS - 1; k >= 0; k--) begin
      idx = rr_ptr + CHAN_BITS'(k);
      if (elig[idx]) begin
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/spio_hss_multiplexer_pkt_scheduler.sv
// Packet channel scheduler ahead of the HSS frame assembler.
// Round-robins eligible channels into frames of up to MAX_PKTS packets, closes a
// frame on fill or idle timeout, and only opens frames while frame credit remains.
module spio_hss_multiplexer_pkt_scheduler
  import spio_hss_multiplexer_pkt_scheduler_pkg::*;
#(
  parameter int MAX_PKTS  = MAX_PKTS_DFLT,
  parameter int FILL_TO   = FILL_TO_DFLT,
  parameter int CRDT_BITS = CRDT_BITS_DFLT,
  parameter int INIT_CRDT = INIT_CRDT_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CHANS-1:0] ch_vld,
  input  logic [NUM_CHANS-1:0] cfc_rem,
  output logic                 gnt_vld,
  output logic [CHAN_BITS-1:0] gnt_ch,
  input  logic                 gnt_rdy,
  output logic                 frm_end,
  input  logic                 crdt_ret,
  output logic [CRDT_BITS-1:0] reg_crdt,
  output logic                 reg_ooc,
  output logic                 reg_cerr
);

  localparam int CNT_BITS = $clog2(MAX_PKTS + 1);
  localparam int TO_BITS  = (FILL_TO > 1) ? $clog2(FILL_TO) : 1;

  localparam logic [CNT_BITS-1:0]  LAST_PKT  = CNT_BITS'(MAX_PKTS - 1);
  localparam logic [TO_BITS-1:0]   LAST_IDLE = TO_BITS'(FILL_TO - 1);
  localparam logic [CRDT_BITS-1:0] CRDT_MAX  = CRDT_BITS'(INIT_CRDT);

  sched_state_e         state_q, state_d;
  logic                 gnt_vld_q, gnt_vld_d;
  logic [CHAN_BITS-1:0] gnt_ch_q, gnt_ch_d;
  logic                 frm_end_q, frm_end_d;
  logic [CNT_BITS-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [TO_BITS-1:0]   to_cnt_q, to_cnt_d;
  logic [CHAN_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [CRDT_BITS-1:0] crdt_q, crdt_d;
  logic                 ooc_q, ooc_d;
  logic                 cerr_q, cerr_d;

  logic                 accept;
  logic [NUM_CHANS-1:0] acc_mask;
  logic [NUM_CHANS-1:0] elig;
  logic [CHAN_BITS-1:0] pick_ptr;
  logic [CHAN_BITS-1:0] pick;
  logic                 any_elig;
  logic                 crdt_zero;

  // Eligibility, with the channel being popped this cycle hidden until next cycle
  always_comb begin
    accept   = (state_q == ST_GRANT) && gnt_rdy;
    acc_mask = accept ? (NUM_CHANS'(1) << gnt_ch_q) : '0;
    elig     = ch_vld & ~cfc_rem & ~acc_mask;
    pick_ptr = accept ? chan_inc(gnt_ch_q) : rr_ptr_q;
    crdt_zero = (crdt_q == '0);
  end

  spio_hss_multiplexer_rr_pick u_rr_pick (
    .elig   (elig),
    .rr_ptr (pick_ptr),
    .pick   (pick),
    .any    (any_elig)
  );

  // Frame FSM: next state, grant and frame-close decisions
  always_comb begin
    state_d   = state_q;
    gnt_vld_d = gnt_vld_q;
    gnt_ch_d  = gnt_ch_q;
    frm_end_d = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    to_cnt_d  = to_cnt_q;
    rr_ptr_d  = accept ? chan_inc(gnt_ch_q) : rr_ptr_q;

    case (state_q)
      ST_IDLE: begin
        gnt_vld_d = 1'b0;
        // Credit is only checked when opening a frame
        if (any_elig && !crdt_zero) begin
          gnt_ch_d  = pick;
          gnt_vld_d = 1'b1;
          pkt_cnt_d = '0;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Grant is held untouched until the assembler takes it
        if (gnt_rdy) begin
          pkt_cnt_d = pkt_cnt_q + 1'b1;
          if (pkt_cnt_q == LAST_PKT) begin
            gnt_vld_d = 1'b0;
            frm_end_d = 1'b1;
            state_d   = ST_CLOSE;
          end else if (any_elig) begin
            gnt_ch_d = pick;
          end else begin
            gnt_vld_d = 1'b0;
            to_cnt_d  = '0;
            state_d   = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (any_elig) begin
          gnt_ch_d  = pick;
          gnt_vld_d = 1'b1;
          state_d   = ST_GRANT;
        end else if (to_cnt_q == LAST_IDLE) begin
          frm_end_d = 1'b1;
          state_d   = ST_CLOSE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_CLOSE: begin
        state_d = ST_IDLE;
      end
      default: begin
        gnt_vld_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Frame credit: spend one per closed frame, regain one per return pulse
  always_comb begin
    crdt_d = crdt_q;
    cerr_d = cerr_q;
    if (crdt_ret && !frm_end_q) begin
      if (crdt_q == CRDT_MAX) begin
        cerr_d = 1'b1;
      end else begin
        crdt_d = crdt_q + 1'b1;
      end
    end else if (frm_end_q && !crdt_ret && !crdt_zero) begin
      crdt_d = crdt_q - 1'b1;
    end
    ooc_d = (state_q == ST_IDLE) && any_elig && crdt_zero;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_vld_q <= 1'b0;
      gnt_ch_q  <= '0;
      frm_end_q <= 1'b0;
      pkt_cnt_q <= '0;
      to_cnt_q  <= '0;
      rr_ptr_q  <= '0;
      crdt_q    <= CRDT_MAX;
      ooc_q     <= 1'b0;
      cerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_ch_q  <= gnt_ch_d;
      frm_end_q <= frm_end_d;
      pkt_cnt_q <= pkt_cnt_d;
      to_cnt_q  <= to_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      crdt_q    <= crdt_d;
      ooc_q     <= ooc_d;
      cerr_q    <= cerr_d;
    end
  end

  assign gnt_vld  = gnt_vld_q;
  assign gnt_ch   = gnt_ch_q;
  assign frm_end  = frm_end_q;
  assign reg_crdt = crdt_q;
  assign reg_ooc  = ooc_q;
  assign reg_cerr = cerr_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_pkt_scheduler.sv
// Self-checking bench for the HSS multiplexer packet scheduler.
// Expected grant channels are queued when traffic is set up and popped on each accept.
module tb_spio_hss_multiplexer_pkt_scheduler;

  localparam int FILL_TO   = 16;
  localparam int INIT_CRDT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ch_vld;
  logic [7:0] cfc_rem;
  logic       gnt_vld;
  logic [2:0] gnt_ch;
  logic       gnt_rdy;
  logic       frm_end;
  logic       crdt_ret;
  logic [3:0] reg_crdt;
  logic       reg_ooc;
  logic       reg_cerr;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_ch;

  always #5 clk = ~clk;

  spio_hss_multiplexer_pkt_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .ch_vld   (ch_vld),
    .cfc_rem  (cfc_rem),
    .gnt_vld  (gnt_vld),
    .gnt_ch   (gnt_ch),
    .gnt_rdy  (gnt_rdy),
    .frm_end  (frm_end),
    .crdt_ret (crdt_ret),
    .reg_crdt (reg_crdt),
    .reg_ooc  (reg_ooc),
    .reg_cerr (reg_cerr)
  );

  task automatic do_reset();
    rst = 1'b1; ch_vld = '0; cfc_rem = '0; gnt_rdy = 1'b0; crdt_ret = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_vld = 8'hFF; cfc_rem = '0; gnt_rdy = 1'b1; crdt_ret = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL reset_gnt_vld: got %b want 0", gnt_vld); end
    n_cmp++; if (gnt_ch !== 3'd0) begin n_err++; $display("FAIL reset_gnt_ch: got %0d want 0", gnt_ch); end
    n_cmp++; if (frm_end !== 1'b0) begin n_err++; $display("FAIL reset_frm_end: got %b want 0", frm_end); end
    n_cmp++; if (reg_crdt !== 4'(INIT_CRDT)) begin n_err++; $display("FAIL reset_crdt: got %0d want %0d", reg_crdt, INIT_CRDT); end
    n_cmp++; if (reg_ooc !== 1'b0) begin n_err++; $display("FAIL reset_ooc: got %b want 0", reg_ooc); end
    n_cmp++; if (reg_cerr !== 1'b0) begin n_err++; $display("FAIL reset_cerr: got %b want 0", reg_cerr); end
    rst = 1'b0; ch_vld = '0; gnt_rdy = 1'b0; crdt_ret = 1'b0;
    @(negedge clk);
    n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL idle_gnt_vld: got %b want 0", gnt_vld); end
    $display("reset: outputs checked");
  endtask

  task automatic test_round_robin();
    int acc;
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    ch_vld = 8'hFF; gnt_rdy = 1'b1; acc = 0;
    for (int cyc = 0; cyc < 40 && acc < 8; cyc++) begin
      @(negedge clk);
      n_cmp++; if (frm_end !== 1'b0) begin n_err++; $display("FAIL rr_early_frm_end: got %b want 0", frm_end); end
      if (gnt_vld && gnt_rdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rr_grant: got ch %0d want none", gnt_ch); end
        else begin
          exp_ch = exp_q.pop_front();
          if (gnt_ch !== exp_ch) begin n_err++; $display("FAIL rr_grant: got ch %0d want %0d", gnt_ch, exp_ch); end
        end
        $display("rr: grant ch=%0d", gnt_ch);
        acc++;
      end
    end
    n_cmp++; if (acc != 8) begin n_err++; $display("FAIL rr_accepts: got %0d want 8", acc); end
    @(negedge clk);
    n_cmp++; if (frm_end !== 1'b1) begin n_err++; $display("FAIL rr_frm_end: got %b want 1", frm_end); end
    n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL rr_close_gnt_vld: got %b want 0", gnt_vld); end
    ch_vld = '0; gnt_rdy = 1'b0;
    @(negedge clk);
    n_cmp++; if (frm_end !== 1'b0) begin n_err++; $display("FAIL rr_frm_end_width: got %b want 0", frm_end); end
    n_cmp++; if (reg_crdt !== 4'd7) begin n_err++; $display("FAIL rr_crdt: got %0d want 7", reg_crdt); end
  endtask

  task automatic test_remote_fc();
    int acc;
    logic [2:0] seq [8];
    seq = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd3};
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(seq[i]);
    ch_vld = 8'hFF; cfc_rem = 8'b0000_0110; gnt_rdy = 1'b1; acc = 0;
    for (int cyc = 0; cyc < 40 && acc < 8; cyc++) begin
      @(negedge clk);
      if (gnt_vld && gnt_rdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL fc_grant: got ch %0d want none", gnt_ch); end
        else begin
          exp_ch = exp_q.pop_front();
          if (gnt_ch !== exp_ch) begin n_err++; $display("FAIL fc_grant: got ch %0d want %0d", gnt_ch, exp_ch); end
        end
        $display("fc: grant ch=%0d", gnt_ch);
        acc++;
      end
    end
    n_cmp++; if (acc != 8) begin n_err++; $display("FAIL fc_accepts: got %0d want 8", acc); end
    @(negedge clk);
    n_cmp++; if (frm_end !== 1'b1) begin n_err++; $display("FAIL fc_frm_end: got %b want 1", frm_end); end
    ch_vld = '0; cfc_rem = '0; gnt_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_timeout();
    bit got;
    do_reset();
    exp_q.push_back(3'd5);
    ch_vld = 8'h20; gnt_rdy = 1'b1; got = 0;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      @(negedge clk);
      if (gnt_vld && gnt_rdy) begin
        n_cmp++;
        exp_ch = exp_q.pop_front();
        if (gnt_ch !== exp_ch) begin n_err++; $display("FAIL fill_grant: got ch %0d want %0d", gnt_ch, exp_ch); end
        $display("fill: grant ch=%0d", gnt_ch);
        ch_vld = '0;
        got = 1;
      end
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL fill_no_grant: got none want ch 5"); end
    for (int k = 1; k <= FILL_TO + 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (frm_end !== (k == FILL_TO + 1)) begin
        n_err++; $display("FAIL fill_frm_end: cycle %0d got %b want %b", k, frm_end, (k == FILL_TO + 1));
      end
      n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL fill_second_grant: cycle %0d got gnt_vld %b want 0", k, gnt_vld); end
    end
    n_cmp++; if (reg_crdt !== 4'd7) begin n_err++; $display("FAIL fill_crdt: got %0d want 7", reg_crdt); end
    gnt_rdy = 1'b0;
  endtask

  task automatic test_credit_simul();
    bit got, seen;
    do_reset();
    exp_q.push_back(3'd2);
    ch_vld = 8'h04; gnt_rdy = 1'b1; got = 0; seen = 0;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      @(negedge clk);
      if (gnt_vld && gnt_rdy) begin
        n_cmp++;
        exp_ch = exp_q.pop_front();
        if (gnt_ch !== exp_ch) begin n_err++; $display("FAIL crdt_grant: got ch %0d want %0d", gnt_ch, exp_ch); end
        $display("crdt: grant ch=%0d", gnt_ch);
        ch_vld = '0;
        got = 1;
      end
    end
    for (int cyc = 0; cyc < FILL_TO + 8 && !seen; cyc++) begin
      @(negedge clk);
      gnt_rdy = 1'b0;
      if (frm_end) begin
        crdt_ret = 1'b1;
        seen = 1;
      end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL crdt_no_frm_end: got none want one pulse"); end
    @(negedge clk);
    crdt_ret = 1'b0;
    n_cmp++; if (reg_crdt !== 4'(INIT_CRDT)) begin n_err++; $display("FAIL crdt_simul: got %0d want %0d", reg_crdt, INIT_CRDT); end
    n_cmp++; if (reg_cerr !== 1'b0) begin n_err++; $display("FAIL crdt_simul_cerr: got %b want 0", reg_cerr); end
    $display("crdt: simultaneous return and close, crdt=%0d", reg_crdt);
    crdt_ret = 1'b1;
    @(negedge clk);
    crdt_ret = 1'b0;
    n_cmp++; if (reg_crdt !== 4'(INIT_CRDT)) begin n_err++; $display("FAIL crdt_sat: got %0d want %0d", reg_crdt, INIT_CRDT); end
    n_cmp++; if (reg_cerr !== 1'b1) begin n_err++; $display("FAIL crdt_cerr_set: got %b want 1", reg_cerr); end
    repeat (3) @(negedge clk);
    n_cmp++; if (reg_cerr !== 1'b1) begin n_err++; $display("FAIL crdt_cerr_sticky: got %b want 1", reg_cerr); end
    $display("crdt: saturating return, cerr=%b", reg_cerr);
    do_reset();
    n_cmp++; if (reg_cerr !== 1'b0) begin n_err++; $display("FAIL crdt_cerr_clear: got %b want 0", reg_cerr); end
  endtask

  task automatic test_credit_exhaust();
    int frames;
    do_reset();
    for (int f = 0; f < INIT_CRDT; f++)
      for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    ch_vld = 8'hFF; gnt_rdy = 1'b1; frames = 0;
    for (int cyc = 0; cyc < 300 && frames < INIT_CRDT; cyc++) begin
      @(negedge clk);
      if (frm_end) frames++;
      if (gnt_vld && gnt_rdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL exh_grant: got ch %0d want none", gnt_ch); end
        else begin
          exp_ch = exp_q.pop_front();
          if (gnt_ch !== exp_ch) begin n_err++; $display("FAIL exh_grant: got ch %0d want %0d", gnt_ch, exp_ch); end
        end
        $display("exh: grant ch=%0d", gnt_ch);
      end
    end
    n_cmp++; if (frames != INIT_CRDT) begin n_err++; $display("FAIL exh_frames: got %0d want %0d", frames, INIT_CRDT); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL exh_gnt_vld: got %b want 0", gnt_vld); end
    end
    n_cmp++; if (reg_crdt !== 4'd0) begin n_err++; $display("FAIL exh_crdt: got %0d want 0", reg_crdt); end
    n_cmp++; if (reg_ooc !== 1'b1) begin n_err++; $display("FAIL exh_ooc: got %b want 1", reg_ooc); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL exh_left: got %0d grants pending want 0", exp_q.size()); end
    gnt_rdy = 1'b0;
    crdt_ret = 1'b1;
    @(negedge clk);
    crdt_ret = 1'b0;
    n_cmp++; if (reg_crdt !== 4'd1) begin n_err++; $display("FAIL exh_ret_crdt: got %0d want 1", reg_crdt); end
    @(negedge clk);
    n_cmp++; if (reg_ooc !== 1'b0) begin n_err++; $display("FAIL exh_ooc_drop: got %b want 0", reg_ooc); end
    n_cmp++; if (gnt_vld !== 1'b1) begin n_err++; $display("FAIL exh_regrant: got %b want 1", gnt_vld); end
    n_cmp++; if (gnt_ch !== 3'd0) begin n_err++; $display("FAIL exh_regrant_ch: got %0d want 0", gnt_ch); end
    $display("exh: credit returned, grant ch=%0d", gnt_ch);
  endtask

  task automatic test_grant_stability();
    bit got;
    do_reset();
    exp_q.push_back(3'd3);
    ch_vld = 8'h08; gnt_rdy = 1'b0; got = 0;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      @(negedge clk);
      if (gnt_vld) got = 1;
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL stab_no_grant: got none want ch 3"); end
    ch_vld = '0; cfc_rem = 8'h08;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++; if (gnt_vld !== 1'b1) begin n_err++; $display("FAIL stab_vld: cycle %0d got %b want 1", k, gnt_vld); end
      n_cmp++; if (gnt_ch !== 3'd3) begin n_err++; $display("FAIL stab_ch: cycle %0d got %0d want 3", k, gnt_ch); end
    end
    gnt_rdy = 1'b1; cfc_rem = '0;
    n_cmp++;
    exp_ch = exp_q.pop_front();
    if (gnt_ch !== exp_ch) begin n_err++; $display("FAIL stab_grant: got ch %0d want %0d", gnt_ch, exp_ch); end
    $display("stab: grant ch=%0d", gnt_ch);
    @(negedge clk);
    gnt_rdy = 1'b0;
    n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL stab_after_acc: got %b want 0", gnt_vld); end
    ch_vld = 8'h40;
    @(negedge clk);
    n_cmp++; if (gnt_vld !== 1'b1 || gnt_ch !== 3'd6) begin
      n_err++; $display("FAIL stab_fill_regrant: got vld %b ch %0d want vld 1 ch 6", gnt_vld, gnt_ch);
    end
    rst = 1'b1; ch_vld = '0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL rst_mid_gnt_vld: got %b want 0", gnt_vld); end
    n_cmp++; if (gnt_ch !== 3'd0) begin n_err++; $display("FAIL rst_mid_gnt_ch: got %0d want 0", gnt_ch); end
    n_cmp++; if (frm_end !== 1'b0) begin n_err++; $display("FAIL rst_mid_frm_end: got %b want 0", frm_end); end
    n_cmp++; if (reg_crdt !== 4'(INIT_CRDT)) begin n_err++; $display("FAIL rst_mid_crdt: got %0d want %0d", reg_crdt, INIT_CRDT); end
    n_cmp++; if (reg_ooc !== 1'b0 || reg_cerr !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_regs: got ooc %b cerr %b want 0 0", reg_ooc, reg_cerr);
    end
    for (int k = 0; k < FILL_TO + 6; k++) begin
      @(negedge clk);
      n_cmp++; if (frm_end !== 1'b0) begin n_err++; $display("FAIL rst_mid_late_frm_end: cycle %0d got %b want 0", k, frm_end); end
    end
    n_cmp++; if (reg_crdt !== 4'(INIT_CRDT)) begin n_err++; $display("FAIL rst_mid_crdt_after: got %0d want %0d", reg_crdt, INIT_CRDT); end
    $display("stab: reset mid-frame, outputs cleared");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_remote_fc();
    test_fill_timeout();
    test_credit_simul();
    test_credit_exhaust();
    test_grant_stability();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
